pico_mem2wb: RTL and testbench
==============================

Name: pico_mem2wb

Overview:
- Bridge from the PicoRV32 native memory interface to a single-master Wishbone bus.
- Sits directly upstream of the Wishbone client peripherals, e.g. the 8-bit output port; it produces the STB/WE/DAT strobes they consume and waits for their ACK.
- Converts one CPU mem_valid request into exactly one Wishbone cycle and returns mem_ready/mem_rdata.
- Bus-timeout watchdog: a non-responding slave cannot hang the CPU.

Parameters:
- TIMEOUT, 16: maximum number of cycles STB_O is held without ACK_I before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: mem_rdata value returned on a timed-out access.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU request valid; held until mem_ready.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 4'h0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- WE_O  out  1  write enable.
- ADR_O  out  32  address.
- SEL_O  out  4  byte lane select.
- DAT_O  out  32  write data. Byte slaves connect to DAT_O[7:0] and DAT_I[7:0].
- DAT_I  in  32  read data from slave.
- ACK_I  in  1  slave acknowledge.
- ERR_O  out  1  one-cycle pulse on timeout abort.

Behaviour:
- All outputs are registered.
- Reset (RST_I=1 at a rising edge), all of the following are 0: mem_ready, mem_rdata, CYC_O, STB_O, WE_O, ADR_O, SEL_O, DAT_O, ERR_O. State becomes IDLE and the timeout count clears.
- State machine:
  - IDLE -> REQ when mem_valid=1 at the edge.
  - REQ -> DONE on ACK_I=1, or on timeout.
  - DONE -> IDLE unconditionally.
- IDLE->REQ edge actions:
  - CYC_O=STB_O=1.
  - ADR_O=mem_addr and DAT_O=mem_wdata.
  - WE_O = |mem_wstrb.
  - SEL_O = mem_wstrb for a write, 4'hF for a read.
  - Timeout count cleared.
- ADR_O, DAT_O, SEL_O and WE_O are stable for the whole REQ state.
- In REQ with ACK_I=1 at an edge:
  - CYC_O=STB_O=WE_O=0.
  - mem_rdata = DAT_I for a read, unchanged for a write.
  - mem_ready=1; go to DONE.
- In REQ with ACK_I=0: count increments. If TIMEOUT!=0 and count==TIMEOUT-1 at that edge, abort:
  - CYC_O=STB_O=WE_O=0.
  - mem_rdata=ERR_RDATA.
  - mem_ready=1 and ERR_O=1; go to DONE.
- STB_O is therefore high for exactly TIMEOUT cycles on a timeout.
- ACK_I and timeout at the same edge: ACK wins; ERR_O stays 0 and data comes from DAT_I.
- DONE: mem_ready and ERR_O return to 0 at the next edge.
  - mem_valid is not sampled in DONE, so a CPU still holding mem_valid during the mem_ready cycle cannot start a duplicate access.
- Latency with a registered-ACK slave: mem_valid sampled at edge n gives:
  - STB_O high after edge n;
  - ACK_I high after edge n+1;
  - mem_ready high after edge n+2, for one cycle;
  - earliest next STB_O after edge n+4.
- ACK_I while in IDLE or DONE is ignored.
- mem_addr, mem_wdata and mem_wstrb changing during REQ are ignored (already latched).
- Reset mid-transaction drops STB_O immediately at that edge, with no mem_ready and no ERR_O. The CPU is reset by the same RST_I.
- Counter width is clog2(TIMEOUT+1) with a minimum of 1, and it never wraps.

Decomposition:
- Shared package pico_soc_pkg:
  - state encoding constants IDLE/REQ/DONE;
  - default ERR_RDATA;
  - Wishbone SEL_ALL constant 4'hF.
- One sub-module, wb_timeout_cnt: clear/enable/expire counter parameterised by TIMEOUT.
- The FSM and the registers stay in pico_mem2wb.

Test Plan:
- Reset: hold RST_I 3 cycles with mem_valid=1 and ACK_I=1 -> all outputs 0, state IDLE, no STB_O.
- Read: slave acks one cycle after STB with DAT_I=32'h0000_003F; mem_valid, addr 32'h0200_0000, wstrb 0 -> STB_O=1, WE_O=0, SEL_O=4'hF; mem_ready pulses once 2 cycles after the request edge with mem_rdata=32'h3F; STB_O=0 in the mem_ready cycle.
- Byte write: addr 32'h0200_0000, wdata 32'h0000_00A5, wstrb 4'h1, with the byte-output slave attached -> WE_O=1, SEL_O=4'h1, DAT_O[7:0]=8'hA5; slave output becomes 8'hA5; exactly one mem_ready pulse; ERR_O=0.
- Timeout (TIMEOUT=8): ACK_I tied 0 -> STB_O high exactly 8 cycles, then mem_ready=ERR_O=1 for one cycle with mem_rdata=32'hDEAD_BEEF; next request proceeds normally.
- ACK on the timeout edge (TIMEOUT=4): ACK_I at the 4th STB cycle with DAT_I=32'h12 -> mem_rdata=32'h12, ERR_O=0.
- Reset mid-REQ, plus back-to-back requests:
  - RST_I while STB_O=1 -> STB_O=0 after that edge, no mem_ready.
  - mem_valid held high across mem_ready -> exactly one Wishbone cycle per request; new STB_O no earlier than 2 edges after mem_ready.

Source files
------------

// File: rtl/pico_soc_pkg.sv
// -----------------------------------------------------------------------------
// pico_soc_pkg
// Shared definitions for the PicoRV32-to-Wishbone bridge:
//   - wb_state_e     : bridge FSM state encoding (IDLE / REQ / DONE)
//   - ERR_RDATA_DEFAULT : read data returned on a timed-out access
//   - SEL_ALL        : Wishbone byte-lane select covering all four lanes
//   - wb_sel()       : maps PicoRV32 write strobes to a Wishbone SEL value
// -----------------------------------------------------------------------------
package pico_soc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [3:0]  SEL_ALL           = 4'hF;

    // A zero strobe means read; reads select every lane.
    function automatic logic [3:0] wb_sel(input logic [3:0] wstrb);
        logic [3:0] sel;
        if (wstrb != 4'h0) begin
            sel = wstrb;
        end else begin
            sel = SEL_ALL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Saturating cycle counter used as the Wishbone bus-timeout watchdog.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset (clears the count)
//   clr    in  synchronous clear (priority over en)
//   en     in  count one cycle of waiting
//   expire out high while the count equals TIMEOUT-1 (never with TIMEOUT=0)
// -----------------------------------------------------------------------------
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic [CW-1:0] MAX  = {CW{1'b1}};

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear wins, otherwise count up and hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 32'd0) && (cnt_q == LAST);

endmodule

// File: rtl/pico_mem2wb.sv
// -----------------------------------------------------------------------------
// pico_mem2wb
// Bridge from the PicoRV32 native memory interface to a single-master
// Wishbone bus. Each mem_valid request becomes exactly one Wishbone cycle;
// a watchdog aborts cycles the slave never acknowledges.
// Ports:
//   CLK_I, RST_I            clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb  CPU request (wstrb==0 is a read)
//   mem_ready, mem_rdata    one-cycle completion pulse and read data
//   CYC_O, STB_O, WE_O, ADR_O, SEL_O, DAT_O   Wishbone master outputs
//   DAT_I, ACK_I            Wishbone slave response
//   ERR_O                   one-cycle pulse on a timeout abort
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pico_mem2wb
    import pico_soc_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [3:0]  SEL_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    output logic        ERR_O
);

    wb_state_e   state_d,     state_q;
    logic        mem_ready_d, mem_ready_q;
    logic [31:0] mem_rdata_d, mem_rdata_q;
    logic        cyc_d,       cyc_q;
    logic        stb_d,       stb_q;
    logic        we_d,        we_q;
    logic [31:0] adr_d,       adr_q;
    logic [3:0]  sel_d,       sel_q;
    logic [31:0] dat_d,       dat_q;
    logic        err_d,       err_q;

    logic        cnt_clr_s;
    logic        cnt_en_s;
    logic        cnt_expire_s;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (CLK_I),
        .rst    (RST_I),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .expire (cnt_expire_s)
    );

    // Bridge FSM next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        mem_ready_d = mem_ready_q;
        mem_rdata_d = mem_rdata_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        err_d       = err_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;

        case (state_q)
            IDLE: begin
                // Counter held clear here so it starts at zero in REQ.
                cnt_clr_s   = 1'b1;
                mem_ready_d = 1'b0;
                err_d       = 1'b0;
                if (mem_valid) begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    we_d    = |mem_wstrb;
                    sel_d   = wb_sel(mem_wstrb);
                end else begin
                    state_d = IDLE;
                end
            end

            REQ: begin
                // ACK has priority over a simultaneous timeout.
                if (ACK_I) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                    if (!we_q) begin
                        mem_rdata_d = DAT_I;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                end else if (cnt_expire_s) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    mem_rdata_d = ERR_RDATA;
                    mem_ready_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_en_s = 1'b1;
                    state_d  = REQ;
                end
            end

            DONE: begin
                // mem_valid deliberately ignored: the CPU may still hold it.
                mem_ready_d = 1'b0;
                err_d       = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                we_d        = 1'b0;
                mem_ready_d = 1'b0;
                err_d       = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0000_0000;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0000_0000;
            sel_q       <= 4'h0;
            dat_q       <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            err_q       <= err_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign CYC_O     = cyc_q;
    assign STB_O     = stb_q;
    assign WE_O      = we_q;
    assign ADR_O     = adr_q;
    assign SEL_O     = sel_q;
    assign DAT_O     = dat_q;
    assign ERR_O     = err_q;

endmodule

// File: tb/tb_pico_mem2wb.sv
// -----------------------------------------------------------------------------
// tb_pico_mem2wb
// Directed bench: one bridge with TIMEOUT=8 driving a registered-ACK byte
// output slave, and a second bridge with TIMEOUT=4 whose ACK is driven by hand.
// -----------------------------------------------------------------------------
module tb_pico_mem2wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    // TIMEOUT=8 instance
    logic        rdy8, cyc8, stb8, we8, err8, ack8;
    logic [31:0] rdata8, adr8, dat8;
    logic [3:0]  sel8;
    logic [31:0] dat_i8;
    logic        slave_ack_r;
    logic        slave_on;
    logic        ack_force;
    logic [7:0]  port_r;

    // TIMEOUT=4 instance
    logic        rdy4, cyc4, stb4, we4, err4, ack4;
    logic [31:0] rdata4, adr4, dat4, dat_i4;
    logic [3:0]  sel4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign ack8 = slave_ack_r | ack_force;

    pico_mem2wb #(.TIMEOUT(8)) dut (
        .CLK_I(clk), .RST_I(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy8), .mem_rdata(rdata8),
        .CYC_O(cyc8), .STB_O(stb8), .WE_O(we8), .ADR_O(adr8), .SEL_O(sel8), .DAT_O(dat8),
        .DAT_I(dat_i8), .ACK_I(ack8), .ERR_O(err8)
    );

    pico_mem2wb #(.TIMEOUT(4)) dut4 (
        .CLK_I(clk), .RST_I(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy4), .mem_rdata(rdata4),
        .CYC_O(cyc4), .STB_O(stb4), .WE_O(we4), .ADR_O(adr4), .SEL_O(sel4), .DAT_O(dat4),
        .DAT_I(dat_i4), .ACK_I(ack4), .ERR_O(err4)
    );

    // Registered-ACK byte output slave on DAT_O[7:0].
    always @(posedge clk) begin
        if (rst) begin
            slave_ack_r <= 1'b0;
            port_r      <= 8'h00;
        end else begin
            slave_ack_r <= slave_on && stb8 && !slave_ack_r;
            if (slave_on && stb8 && we8 && sel8[0] && !slave_ack_r) begin
                port_r <= dat8[7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stb_cnt;
        int last_rdy;
        int rises;
        int readies;
        logic prev_stb;

        rst = 1'b1; mem_valid = 1'b1; mem_addr = 32'h1234_5678;
        mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
        slave_on = 1'b1; ack_force = 1'b1; dat_i8 = 32'h0; dat_i4 = 32'h0; ack4 = 1'b0;

        // ---------------- reset with mem_valid and ACK asserted
        repeat (3) tick();
        check("rst_ready", {31'h0, rdy8}, 32'h0);
        check("rst_rdata", rdata8, 32'h0);
        check("rst_cyc",   {31'h0, cyc8}, 32'h0);
        check("rst_stb",   {31'h0, stb8}, 32'h0);
        check("rst_we",    {31'h0, we8}, 32'h0);
        check("rst_adr",   adr8, 32'h0);
        check("rst_sel",   {28'h0, sel8}, 32'h0);
        check("rst_dat",   dat8, 32'h0);
        check("rst_err",   {31'h0, err8}, 32'h0);
        mem_valid = 1'b0; ack_force = 1'b0; mem_wstrb = 4'h0;
        rst = 1'b0;
        tick();

        // ---------------- ACK while idle is ignored
        ack_force = 1'b1;
        tick(); tick();
        check("idle_ack_ready", {31'h0, rdy8}, 32'h0);
        check("idle_ack_stb",   {31'h0, stb8}, 32'h0);
        ack_force = 1'b0;
        tick();

        // ---------------- read
        dat_i8 = 32'h0000_003F; mem_addr = 32'h0200_0000; mem_wstrb = 4'h0; mem_valid = 1'b1;
        tick();                               // edge n
        check("rd_stb", {31'h0, stb8}, 32'h1);
        check("rd_cyc", {31'h0, cyc8}, 32'h1);
        check("rd_we",  {31'h0, we8}, 32'h0);
        check("rd_sel", {28'h0, sel8}, 32'hF);
        check("rd_adr", adr8, 32'h0200_0000);
        tick();                               // edge n+1
        check("rd_ready_early", {31'h0, rdy8}, 32'h0);
        tick();                               // edge n+2
        check("rd_ready", {31'h0, rdy8}, 32'h1);
        check("rd_rdata", rdata8, 32'h0000_003F);
        check("rd_stb_low", {31'h0, stb8}, 32'h0);
        mem_valid = 1'b0;
        tick();
        check("rd_ready_pulse", {31'h0, rdy8}, 32'h0);
        repeat (4) tick();

        // ---------------- byte write
        mem_addr = 32'h0200_0000; mem_wdata = 32'h0000_00A5; mem_wstrb = 4'h1; mem_valid = 1'b1;
        tick();
        check("wr_we",  {31'h0, we8}, 32'h1);
        check("wr_sel", {28'h0, sel8}, 32'h1);
        check("wr_dat", {24'h0, dat8[7:0]}, 32'hA5);
        mem_addr = 32'h0400_0000; mem_wdata = 32'h0000_005A; mem_wstrb = 4'h2;
        tick();
        check("wr_adr_stable", adr8, 32'h0200_0000);
        check("wr_dat_stable", dat8, 32'h0000_00A5);
        check("wr_sel_stable", {28'h0, sel8}, 32'h1);
        tick();
        check("wr_ready", {31'h0, rdy8}, 32'h1);
        check("wr_err",   {31'h0, err8}, 32'h0);
        check("wr_rdata_kept", rdata8, 32'h0000_003F);
        check("wr_port",  {24'h0, port_r}, 32'hA5);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        tick();
        check("wr_ready_once", {31'h0, rdy8}, 32'h0);
        repeat (4) tick();

        // ---------------- timeout on the TIMEOUT=8 bridge
        slave_on = 1'b0; mem_addr = 32'h0300_0000; mem_valid = 1'b1;
        tick();
        stb_cnt = stb8 ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stb8) stb_cnt++;
            if (rdy8) break;
        end
        check("to_ready", {31'h0, rdy8}, 32'h1);
        check("to_err",   {31'h0, err8}, 32'h1);
        check("to_rdata", rdata8, 32'hDEAD_BEEF);
        check("to_stb_cycles", stb_cnt, 32'd8);
        mem_valid = 1'b0;
        tick();
        check("to_err_pulse", {31'h0, err8}, 32'h0);
        slave_on = 1'b1;
        repeat (4) tick();
        dat_i8 = 32'h0000_0011; mem_valid = 1'b1;
        tick(); tick(); tick();
        check("after_to_ready", {31'h0, rdy8}, 32'h1);
        check("after_to_rdata", rdata8, 32'h0000_0011);
        check("after_to_err",   {31'h0, err8}, 32'h0);
        mem_valid = 1'b0;
        repeat (6) tick();

        // ---------------- ACK on the timeout edge (TIMEOUT=4 bridge)
        dat_i4 = 32'h0000_0012; mem_addr = 32'h0500_0000; mem_valid = 1'b1;
        tick();                               // edge n: STB cycle 1
        check("t4_stb", {31'h0, stb4}, 32'h1);
        mem_valid = 1'b0;
        tick(); tick(); tick();               // STB cycles 2..4
        check("t4_no_ready_yet", {31'h0, rdy4}, 32'h0);
        ack4 = 1'b1;
        tick();                               // edge n+4: ACK and expiry together
        check("t4_ready", {31'h0, rdy4}, 32'h1);
        check("t4_err",   {31'h0, err4}, 32'h0);
        check("t4_rdata", rdata4, 32'h0000_0012);
        ack4 = 1'b0;
        repeat (6) tick();

        // ---------------- plain timeout on TIMEOUT=4 bridge
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick(); tick(); tick();
        check("t4_to_stb_4th", {31'h0, stb4}, 32'h1);
        tick();
        check("t4_to_err", {31'h0, err4}, 32'h1);
        check("t4_to_rdata", rdata4, 32'hDEAD_BEEF);
        repeat (6) tick();

        // ---------------- reset in the middle of REQ
        slave_on = 1'b0; mem_valid = 1'b1;
        tick(); tick();
        check("mid_stb_before", {31'h0, stb8}, 32'h1);
        rst = 1'b1;
        tick();
        check("mid_stb_after", {31'h0, stb8}, 32'h0);
        check("mid_ready",     {31'h0, rdy8}, 32'h0);
        check("mid_err",       {31'h0, err8}, 32'h0);
        rst = 1'b0; mem_valid = 1'b0; slave_on = 1'b1;
        tick();
        check("mid_ready_post", {31'h0, rdy8}, 32'h0);
        repeat (2) tick();

        // ---------------- back-to-back with mem_valid held high
        dat_i8 = 32'h0000_0077; mem_valid = 1'b1;
        prev_stb = 1'b0; last_rdy = -100; rises = 0; readies = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (stb8 && !prev_stb) begin
                rises++;
                if (rises > 1) check("b2b_gap", t - last_rdy, 32'd2);
            end
            if (rdy8) begin
                readies++;
                last_rdy = t;
            end
            prev_stb = stb8;
        end
        check("b2b_rises",   rises, 32'd3);
        check("b2b_readies", readies, 32'd3);
        mem_valid = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
